// File: rtl/image_mem_responder_pkg.sv
// Shared types and defaults for the image memory responder.
package image_mem_responder_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4096;

  // Port indices used by the per-port request/response datapath.
  localparam int PORT_PROC = 0;
  localparam int PORT_HOST = 1;
  localparam int NUM_PORTS = 2;

  // Memory ownership phases.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  // True when an address falls inside the implemented words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < $unsigned(depth);
  endfunction

endpackage

// File: rtl/image_mem_responder_sp_ram.sv
// Single-port synchronous-read RAM, write-first on a write access.
module image_mem_responder_sp_ram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array access: a write also forwards the new word to the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/image_mem_responder.sv
// Memory-side responder: owns the data array, hands it to the host (LOAD/DUMP)
// or the processor (RUN), and produces the processor clock-enable.
module image_mem_responder
  import image_mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_en,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic              proc_run,
  input  logic              end_of_process,
  input  logic              host_start,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  localparam int RAM_AW = $clog2(DEPTH);

  state_t state_reg, state_next;
  logic   addr_err_reg, addr_err_next;

  // Per-port request view (index PORT_PROC / PORT_HOST).
  logic [NUM_PORTS-1:0] req_en;
  logic [NUM_PORTS-1:0] req_we;
  logic [NUM_PORTS-1:0] req_own;
  logic [NUM_PORTS-1:0] req_ok;
  logic [NUM_PORTS-1:0] req_inr;
  logic [ADDR_W-1:0]    req_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0] rvalid_vec;
  logic [DATA_W-1:0]    rdata_vec [NUM_PORTS];

  logic              host_owns;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr_full;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign host_owns = (state_reg != ST_RUN);

  assign req_en[PORT_PROC]   = proc_en;
  assign req_we[PORT_PROC]   = proc_we;
  assign req_addr[PORT_PROC] = proc_addr;
  assign req_own[PORT_PROC]  = ~host_owns;
  assign req_en[PORT_HOST]   = host_en;
  assign req_we[PORT_HOST]   = host_we;
  assign req_addr[PORT_HOST] = host_addr;
  assign req_own[PORT_HOST]  = host_owns;

  // Per-port range check and response pipeline; only the owning port responds.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
      logic              rvalid_reg;
      logic              oor_reg;
      logic [DATA_W-1:0] hold_reg;
      logic [DATA_W-1:0] rdata_now;

      assign req_inr[gi] = addr_in_range(32'(req_addr[gi]), DEPTH);
      assign req_ok[gi]  = req_en[gi] & req_own[gi];

      // Out-of-range reads return zero; otherwise the RAM's registered word.
      assign rdata_now = oor_reg ? '0 : ram_rdata;

      // Read-valid pulse, range flag of the read, and last delivered word.
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
          oor_reg    <= 1'b0;
          hold_reg   <= '0;
        end else begin
          rvalid_reg <= req_ok[gi] & ~req_we[gi];
          oor_reg    <= ~req_inr[gi];
          if (rvalid_reg) begin
            hold_reg <= rdata_now;
          end
        end
      end

      assign rvalid_vec[gi] = rvalid_reg;
      assign rdata_vec[gi]  = rvalid_reg ? rdata_now : hold_reg;
    end
  endgenerate

  // Single-port array: the owner drives it, out-of-range accesses never reach it.
  assign ram_addr_full = host_owns ? host_addr  : proc_addr;
  assign ram_wdata     = host_owns ? host_wdata : proc_wdata;
  assign ram_we        = host_owns ? host_we    : proc_we;
  assign ram_en        = ~rst & (host_owns ? (req_ok[PORT_HOST] & req_inr[PORT_HOST])
                                           : (req_ok[PORT_PROC] & req_inr[PORT_PROC]));

  image_mem_responder_sp_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr_full[RAM_AW-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Phase register and sticky address-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_LOAD;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_err_reg <= addr_err_next;
    end
  end

  // Phase transitions and error-flag update; starting a run clears the flag.
  always_comb begin
    state_next    = state_reg;
    addr_err_next = addr_err_reg;
    if (|(req_ok & ~req_inr)) begin
      addr_err_next = 1'b1;
    end
    case (state_reg)
      ST_LOAD: begin
        if (host_start) begin
          state_next    = ST_RUN;
          addr_err_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (end_of_process) begin
          state_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (host_start) begin
          state_next = ST_LOAD;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  assign busy        = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DUMP);
  assign proc_run    = busy;
  assign addr_err    = addr_err_reg;
  assign proc_rvalid = rvalid_vec[PORT_PROC];
  assign proc_rdata  = rdata_vec[PORT_PROC];
  assign host_rvalid = rvalid_vec[PORT_HOST];
  assign host_rdata  = rdata_vec[PORT_HOST];

endmodule

// File: tb/tb_image_mem_responder.sv
// Randomised self-checking bench for image_mem_responder with a word-array model.
module tb_image_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        proc_en, proc_we;
  logic [15:0] proc_addr, proc_wdata, proc_rdata;
  logic        proc_rvalid, proc_run, end_of_process, host_start;
  logic        host_en, host_we;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        host_rvalid, busy, done, addr_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] model_mem [4096];
  logic [15:0] proc_last;
  logic [15:0] host_last;

  always #5 clk = ~clk;

  image_mem_responder dut (
    .clk(clk), .rst(rst),
    .proc_en(proc_en), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid),
    .proc_run(proc_run), .end_of_process(end_of_process), .host_start(host_start),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .busy(busy), .done(done), .addr_err(addr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_en = 0; proc_we = 0; host_en = 0; host_we = 0;
    host_start = 0; end_of_process = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    proc_addr = 0; proc_wdata = 0; host_addr = 0; host_wdata = 0;
    tick(); tick();
    rst = 0;
    proc_last = 0; host_last = 0;
    total++; if (proc_run !== 1'b0) begin bad++; $display("FAIL rst_proc_run got=%b exp=0", proc_run); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
    total++; if (proc_rvalid !== 1'b0) begin bad++; $display("FAIL rst_proc_rvalid got=%b exp=0", proc_rvalid); end
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rst_host_rvalid got=%b exp=0", host_rvalid); end
    total++; if (proc_rdata !== 16'h0) begin bad++; $display("FAIL rst_proc_rdata got=%h exp=0000", proc_rdata); end
    total++; if (host_rdata !== 16'h0) begin bad++; $display("FAIL rst_host_rdata got=%h exp=0000", host_rdata); end
    $display("reset applied");
  endtask

  // Host read of one address, checked against the model the cycle after.
  task automatic host_read_check(input logic [15:0] a, input string name);
    logic [15:0] exp;
    exp = (a < 16'd4096) ? model_mem[a[11:0]] : 16'h0;
    host_en = 1; host_we = 0; host_addr = a;
    tick();
    host_en = 0;
    total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL %s_rvalid got=%b exp=1", name, host_rvalid); end
    total++; if (host_rdata !== exp) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", name, host_rdata, exp); end
    host_last = exp;
    $display("host rd addr=%h data=%h", a, host_rdata);
  endtask

  task automatic test_host_load();
    for (int i = 0; i < 16; i++) begin
      host_en = 1; host_we = 1; host_addr = 16'(i);
      host_wdata = (i < 4) ? 16'(16'h00AA + i) : 16'($urandom);
      model_mem[i] = host_wdata;
      tick();
      total++; if (host_rvalid !== 1'b0 || proc_run !== 1'b0) begin
        bad++; $display("FAIL load_wr rvalid=%b proc_run=%b exp=0,0", host_rvalid, proc_run);
      end
    end
    host_read_check(16'd2, "load_rd2");
    total++; if (host_rdata !== 16'h00AC) begin bad++; $display("FAIL load_rd2_const got=%h exp=00ac", host_rdata); end
    tick();
    total++; if (host_rvalid !== 1'b0 || host_rdata !== 16'h00AC) begin
      bad++; $display("FAIL load_hold rvalid=%b data=%h exp=0,00ac", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_load_ignore();
    for (int i = 0; i < 8; i++) begin
      proc_en = 1; proc_we = (i < 4); proc_addr = 16'(i % 4); proc_wdata = 16'($urandom);
      tick();
      total++; if (proc_rvalid !== 1'b0) begin bad++; $display("FAIL load_proc_rvalid got=%b exp=0", proc_rvalid); end
    end
    proc_en = 0;
    for (int i = 0; i < 4; i++) host_read_check(16'(i), "load_ignore");
  endtask

  task automatic test_run();
    logic [15:0] a, d, exp;
    logic        w, e, exp_rv;
    host_start = 1;
    tick();
    host_start = 0;
    total++; if (proc_run !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL run_enter run=%b busy=%b done=%b exp=1,1,0", proc_run, busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 15)); d = 16'($urandom);
      w = 1'($urandom_range(0, 1)); e = ($urandom_range(0, 3) != 0);
      proc_en = e; proc_we = w; proc_addr = a; proc_wdata = d;
      host_en = 1'($urandom_range(0, 1)); host_we = 0; host_addr = a;
      exp_rv = e && !w;
      if (e && w) model_mem[a[11:0]] = d;
      exp = exp_rv ? model_mem[a[11:0]] : proc_last;
      tick();
      total++; if (proc_rvalid !== exp_rv || proc_rdata !== exp) begin
        bad++; $display("FAIL run_rand rvalid=%b data=%h exp=%b,%h", proc_rvalid, proc_rdata, exp_rv, exp);
      end
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL run_host_rvalid got=%b exp=0", host_rvalid); end
      proc_last = exp;
      $display("proc op en=%b we=%b addr=%h data=%h", e, w, a, proc_rdata);
    end
    host_en = 0;
    proc_en = 1; proc_we = 1; proc_addr = 16'd5; proc_wdata = 16'h1234;
    model_mem[5] = 16'h1234;
    tick();
    proc_we = 0; host_en = 1; host_addr = 16'd1;
    tick();
    proc_en = 0; host_en = 0;
    total++; if (proc_rvalid !== 1'b1 || proc_rdata !== 16'h1234) begin
      bad++; $display("FAIL run_raw rvalid=%b data=%h exp=1,1234", proc_rvalid, proc_rdata);
    end
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL run_host_ignored got=%b exp=0", host_rvalid); end
    proc_last = 16'h1234;
  endtask

  task automatic test_end_of_process();
    proc_en = 1; proc_we = 0; proc_addr = 16'd0; end_of_process = 1;
    tick();
    proc_en = 0; end_of_process = 0;
    total++; if (proc_rvalid !== 1'b1 || proc_rdata !== 16'h00AA) begin
      bad++; $display("FAIL eop_read rvalid=%b data=%h exp=1,00aa", proc_rvalid, proc_rdata);
    end
    total++; if (done !== 1'b1 || proc_run !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL eop_state done=%b run=%b busy=%b exp=1,0,0", done, proc_run, busy);
    end
    proc_last = 16'h00AA;
    host_read_check(16'd5, "dump_rd5");
    host_en = 1; host_we = 1; host_addr = 16'd9; host_wdata = 16'($urandom);
    model_mem[9] = host_wdata;
    tick();
    host_read_check(16'd9, "dump_wr_rd");
  endtask

  task automatic test_addr_err();
    host_start = 1; tick(); host_start = 0; tick();
    total++; if (done !== 1'b0 || busy !== 1'b0 || proc_run !== 1'b0) begin
      bad++; $display("FAIL dump_to_load done=%b busy=%b run=%b exp=0,0,0", done, busy, proc_run);
    end
    host_start = 1; tick(); host_start = 0;
    proc_en = 1; proc_we = 0; proc_addr = 16'hFFFF;
    tick();
    total++; if (proc_rvalid !== 1'b1 || proc_rdata !== 16'h0 || addr_err !== 1'b1) begin
      bad++; $display("FAIL oor_read rvalid=%b data=%h err=%b exp=1,0000,1", proc_rvalid, proc_rdata, addr_err);
    end
    proc_last = 16'h0;
    proc_we = 1; proc_addr = 16'd4096; proc_wdata = 16'hDEAD;
    tick();
    proc_en = 0; end_of_process = 1;
    tick();
    end_of_process = 0;
    total++; if (addr_err !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL err_sticky err=%b done=%b exp=1,1", addr_err, done);
    end
    host_read_check(16'd0, "oor_wr_discard");
    host_read_check(16'h1000, "host_oor");
    host_start = 1; tick(); host_start = 0;
    total++; if (addr_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL load_keep_err err=%b busy=%b exp=1,0", addr_err, busy);
    end
    host_start = 1; tick(); host_start = 0;
    total++; if (addr_err !== 1'b0 || proc_run !== 1'b1) begin
      bad++; $display("FAIL start_clear err=%b run=%b exp=0,1", addr_err, proc_run);
    end
  endtask

  task automatic test_reset_mid_run();
    proc_en = 1; proc_we = 1; proc_addr = 16'd6; proc_wdata = 16'h5A5A;
    model_mem[6] = 16'h5A5A;
    tick();
    proc_we = 0; proc_addr = 16'd6; rst = 1;
    tick();
    rst = 0; proc_en = 0;
    proc_last = 0; host_last = 0;
    total++; if (proc_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr_err !== 1'b0) begin
      bad++; $display("FAIL midrst_state run=%b busy=%b done=%b err=%b exp=0,0,0,0", proc_run, busy, done, addr_err);
    end
    total++; if (proc_rvalid !== 1'b0 || host_rvalid !== 1'b0 || proc_rdata !== 16'h0 || host_rdata !== 16'h0) begin
      bad++; $display("FAIL midrst_out prv=%b hrv=%b pd=%h hd=%h exp=0,0,0000,0000", proc_rvalid, host_rvalid, proc_rdata, host_rdata);
    end
    host_read_check(16'd5, "midrst_rd5");
    host_read_check(16'd6, "midrst_rd6");
  endtask

  initial begin
    test_reset();
    test_host_load();
    test_load_ignore();
    test_run();
    test_end_of_process();
    test_addr_err();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_mem_responder.md
# image_mem_responder

Memory-side responder for the image-processing system: owns the data memory array and services load/store requests from the processor on the same enable/write-enable/address/data interface the processor drives. A host port loads the source image before a run and reads the processed image back after the processor signals end of process. The block also produces the processor's clock-enable, replacing the bare AND-gate clock gating.

## Interface
- ADDR_W, 16, address width of both ports
- DATA_W, 16, data word width
- DEPTH, 4096, implemented words; addresses ≥ DEPTH are out of range

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- proc_en  in  1  processor memory request strobe (RAM_en role)
- proc_we  in  1  processor write enable, valid with proc_en
- proc_addr  in  ADDR_W  processor address
- proc_wdata  in  DATA_W  processor store data
- proc_rdata  out  DATA_W  load data, valid while proc_rvalid=1
- proc_rvalid  out  1  one-cycle pulse, read data valid
- proc_run  out  1  processor clock-enable; processor advances only when 1
- end_of_process  in  1  processor completion flag (level)
- host_start  in  1  pulse: begin run (accepted only in LOAD)
- host_en, host_we  in  1  host request strobe / write enable
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data, valid with host_rvalid
- host_rvalid  out  1  one-cycle pulse
- busy  out  1  1 in RUN
- done  out  1  1 in DUMP
- addr_err  out  1  sticky: out-of-range access seen since last reset/start

## Operation
- FSM states: LOAD, RUN, DUMP.
- LOAD: host owns memory; proc requests ignored; proc_run=0. host_start=1 → RUN, clears addr_err.
- RUN: processor owns memory; host requests ignored (no host_rvalid); proc_run=1. end_of_process=1 sampled → DUMP.
- DUMP: host owns memory (read and write); proc_run=0. host_start=1 → LOAD (supports next image without reset).
- host_start outside LOAD/DUMP ignored; in DUMP it only returns to LOAD, it does not start a run.
- Write: en=1, we=1, in-range address → word stored at edge. No response pulse.
- Read: en=1, we=0 → rdata registered at edge, rvalid pulses the following cycle.
- Out of range: write discarded; read returns 0 with normal rvalid; addr_err set.
- Back-to-back requests accepted every cycle; read-after-write to same address in consecutive cycles returns new data; a read and write in the same cycle are impossible on one port.
- Only the owning port ever touches the array; single-port memory, no arbitration.
- Reset: state=LOAD, proc_run=0, busy=0, done=0, addr_err=0, proc_rvalid=0, host_rvalid=0, proc_rdata=0, host_rdata=0. Memory contents not cleared. Reset mid-RUN aborts the run immediately (proc_run=0 the next cycle).

## Timing
- Read latency: 1 cycle (request edge N → rvalid/rdata high during cycle N+1).
- proc_run is registered: rises the cycle after host_start is accepted, falls the cycle after end_of_process is sampled.
- A processor request in the same cycle end_of_process is sampled is still serviced; its rvalid still pulses.
- busy/done change on the same edge as the state.
- rdata holds its last value when rvalid=0.

## Structure
- Shared package: state encoding (LOAD/RUN/DUMP), default ADDR_W/DATA_W/DEPTH constants.
- One sub-module: sp_ram (single-port synchronous-read array, DEPTH×DATA_W, write-first); FSM, port mux and range check in the top.

## Test plan
- Reset, host writes 0x00AA..0x00AD to addr 0..3, reads addr 2 → host_rvalid one cycle later with 0x00AC; proc_run=0 throughout.
- host_start → proc_run=1 next cycle; proc writes 0x1234 to addr 5 then reads addr 5 on next cycle → proc_rdata=0x1234 with proc_rvalid; concurrent host read → no host_rvalid.
- Assert end_of_process during a proc read of addr 0 → proc_rvalid with 0x00AA, then state DUMP, done=1, proc_run=0; host reads addr 5 → 0x1234.
- Proc read addr 0xFFFF (DEPTH=4096) in RUN → rdata 0, rvalid pulse, addr_err=1; next host_start in LOAD clears it.
- rst asserted mid-RUN → next cycle LOAD, all outputs at reset values; host read addr 5 still returns 0x1234.
- Proc requests issued while in LOAD → memory unchanged, no proc_rvalid.
